// File: rtl/chip8_fetch_if.sv
// Fetch-stage bus: byte read port toward Chip8_memory, opcode handshake toward
// the decoder, and the PC redirect path from execute.
interface chip8_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              reen;
  logic [ADDR_W-1:0] read_addr;
  logic [7:0]        read_data;
  logic              read_ack;
  logic              op_valid;
  logic              op_ready;
  logic [15:0]       opcode;
  logic [ADDR_W-1:0] op_pc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              fault;

  modport master (
    output reen, read_addr, op_valid, opcode, op_pc, fault,
    input  read_data, read_ack, op_ready, pc_load, pc_load_addr
  );

  modport slave (
    input  reen, read_addr, op_valid, opcode, op_pc, fault,
    output read_data, read_ack, op_ready, pc_load, pc_load_addr
  );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 fetch stage: two byte reads per instruction, big-endian opcode out.
// Optional odd-PC sticky fault enabled by CHIP8_FETCH_ODD_PC_FAULT_EN.
module chip8_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h200
) (
  input logic          clk,
  input logic          rst,
  chip8_fetch_if.master bus
);
  typedef enum logic [2:0] {
    FETCH_HI, WAIT_HI, FETCH_LO, WAIT_LO, VALID, DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] read_addr_q;
  logic              reen_q;
  logic [7:0]        hi;
  logic              op_valid_q;
  logic [15:0]       opcode_q;
  logic [ADDR_W-1:0] op_pc_q;

  // reen_q is loaded on the edge that enters a FETCH state so the request is
  // on the bus during that state; a same-cycle redirect masks it.
  assign bus.reen      = reen_q & ~bus.pc_load;
  assign bus.read_addr = read_addr_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.op_pc     = op_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_HI;
      pc          <= RESET_PC;
      reen_q      <= 1'b0;
      read_addr_q <= '0;
      hi          <= '0;
      op_valid_q  <= 1'b0;
      opcode_q    <= '0;
      op_pc_q     <= '0;
    end else if (bus.pc_load) begin
      pc         <= bus.pc_load_addr;
      op_valid_q <= 1'b0;
      if ((state == WAIT_HI || state == WAIT_LO || state == DRAIN) && !bus.read_ack) begin
        state  <= DRAIN;
        reen_q <= 1'b0;
      end else begin
        state       <= FETCH_HI;
        reen_q      <= 1'b1;
        read_addr_q <= bus.pc_load_addr;
      end
    end else begin
      unique case (state)
        FETCH_HI: begin
          // First cycle out of reset has no request armed yet: arm it here.
          if (reen_q) begin
            state  <= WAIT_HI;
            reen_q <= 1'b0;
          end else begin
            reen_q      <= 1'b1;
            read_addr_q <= pc;
          end
        end
        WAIT_HI: if (bus.read_ack) begin
          hi          <= bus.read_data;
          state       <= FETCH_LO;
          reen_q      <= 1'b1;
          read_addr_q <= pc + ONE;
        end
        FETCH_LO: begin
          state  <= WAIT_LO;
          reen_q <= 1'b0;
        end
        WAIT_LO: if (bus.read_ack) begin
          opcode_q   <= {hi, bus.read_data};
          op_pc_q    <= pc;
          op_valid_q <= 1'b1;
          state      <= VALID;
        end
        VALID: if (bus.op_ready) begin
          op_valid_q  <= 1'b0;
          pc          <= pc + TWO;
          state       <= FETCH_HI;
          reen_q      <= 1'b1;
          read_addr_q <= pc + TWO;
        end
        DRAIN: if (bus.read_ack) begin
          state       <= FETCH_HI;
          reen_q      <= 1'b1;
          read_addr_q <= pc;
        end
        default: begin
          state  <= FETCH_HI;
          reen_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHIP8_FETCH_ODD_PC_FAULT_EN
  logic fault_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          fault_q <= 1'b0;
    else if (state == FETCH_HI && pc[0]) fault_q <= 1'b1;
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif
endmodule

// File: tb/tb_chip8_fetch.sv
// Bench for chip8_fetch: byte memory model with variable ack latency and a
// handshake-level PC/opcode reference model.
module tb_chip8_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chip8_fetch_if #(.ADDR_W(12)) bus ();
  chip8_fetch #(.ADDR_W(12), .RESET_PC(12'h200)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4096];
  int         lat = 1;   // 0 selects a random latency of 1..4 per read

  // memory model: request seen mid-cycle, ack driven `lat` cycles later
  logic       pend = 1'b0;
  int         cnt  = 0;
  logic [11:0] maddr = '0;
  initial begin
    bus.read_ack  = 1'b0;
    bus.read_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.read_ack = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.read_ack  = 1'b1;
          bus.read_data = mem[maddr];
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst && bus.reen) begin
        pend  = 1'b1;
        cnt   = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
        maddr = bus.read_addr;
      end
    end
  end

  int          cyc = 0;
  logic        ov, ov_prev;
  logic [15:0] opc;
  logic [11:0] opp;
  logic [11:0] rq[$];
  int          rc[$];
  int          vc[$];
  logic [15:0] hq_op[$];
  logic [11:0] hq_pc[$];

  function automatic logic [15:0] exp_op(input logic [11:0] p);
    logic [11:0] q;
    q = p + 12'd1;
    return {mem[p], mem[q]};
  endfunction

  task automatic clear_logs();
    rq.delete(); rc.delete(); vc.delete(); hq_op.delete(); hq_pc.delete();
  endtask

  task automatic tick(input logic rdy, input logic ld, input logic [11:0] la);
    @(posedge clk); #2;
    cyc++;
    ov  = bus.op_valid;
    opc = bus.opcode;
    opp = bus.op_pc;
    bus.op_ready     = rdy;
    bus.pc_load      = ld;
    bus.pc_load_addr = la;
    #1;
    if (bus.reen) begin rq.push_back(bus.read_addr); rc.push_back(cyc); end
    if (ov && !ov_prev) vc.push_back(cyc);
    ov_prev = ov;
    if (ov && rdy && !ld) begin hq_op.push_back(opc); hq_pc.push_back(opp); end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    bus.op_ready = 1'b0; bus.pc_load = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    ov_prev = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_hs(input int want, input string nm);
    int n;
    n = 0;
    while (hq_pc.size() < want && n < 200) begin tick(1'b1, 1'b0, '0); n++; end
    checks++;
    if (hq_pc.size() < want) begin
      errors++;
      $display("FAIL %s timeout: handshakes %0d required %0d", nm, hq_pc.size(), want);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.reen, bus.op_valid, bus.fault} !== 3'b000 || bus.read_addr !== 12'h000
        || bus.opcode !== 16'h0000 || bus.op_pc !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: reen=%b op_valid=%b fault=%b read_addr=%h opcode=%h op_pc=%h required all zero",
               bus.reen, bus.op_valid, bus.fault, bus.read_addr, bus.opcode, bus.op_pc);
    end
    do_reset();
  endtask

  task automatic test_basic();
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    lat = 1;
    do_reset();
    run_until_hs(1, "basic");
    tick(1'b1, 1'b0, '0); tick(1'b1, 1'b0, '0);
    checks++;
    if (rq.size() < 3 || rq[0] !== 12'h200 || rq[1] !== 12'h201 || rq[2] !== 12'h202) begin
      errors++;
      $display("FAIL basic_addrs: got %p required 200 201 202", rq);
    end
    checks++;
    if (hq_op.size() < 1 || hq_op[0] !== 16'h1234 || hq_pc[0] !== 12'h200) begin
      errors++;
      $display("FAIL basic_opcode: got %p/%p required 1234/200", hq_op, hq_pc);
    end
    checks++;
    if (vc.size() < 1 || rc.size() < 1 || vc[0] - rc[0] != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges required 4", (vc.size() > 0 && rc.size() > 0) ? vc[0] - rc[0] : -1);
    end
    checks++;
    if (rc.size() < 3 || rc[2] - rc[0] != 5) begin
      errors++;
      $display("FAIL basic_throughput: got %0d cycles required 5", rc.size() > 2 ? rc[2] - rc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] o0;
    logic [11:0] p0;
    int n, nreen;
    lat = 1;
    do_reset();
    n = 0;
    while (!bus.op_valid && n < 50) begin tick(1'b0, 1'b0, '0); n++; end
    o0 = bus.opcode; p0 = bus.op_pc; nreen = rq.size();
    checks++;
    if (o0 !== exp_op(12'h200) || p0 !== 12'h200) begin
      errors++;
      $display("FAIL bp_first: got %h/%h required %h/200", o0, p0, exp_op(12'h200));
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, '0);
      checks++;
      if (bus.opcode !== o0 || bus.op_pc !== p0 || !bus.op_valid || rq.size() != nreen) begin
        errors++;
        $display("FAIL bp_hold[%0d]: opcode=%h op_pc=%h valid=%b reens=%0d required %h/%h/1/%0d",
                 i, bus.opcode, bus.op_pc, bus.op_valid, rq.size(), o0, p0, nreen);
      end
    end
    tick(1'b1, 1'b0, '0);
    repeat (6) tick(1'b0, 1'b0, '0);
    checks++;
    if (hq_pc.size() != 1 || rq.size() <= nreen || rq[nreen] !== 12'h202) begin
      errors++;
      $display("FAIL bp_release: handshakes=%0d next_addr=%h required 1/202",
               hq_pc.size(), rq.size() > nreen ? rq[nreen] : 12'hxxx);
    end
  endtask

  task automatic test_wrap();
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2;
    lat = 1;
    clear_logs();
    tick(1'b0, 1'b1, 12'hFFE);
    run_until_hs(1, "wrap");
    repeat (3) tick(1'b0, 1'b0, '0);
    checks++;
    if (hq_op.size() < 1 || hq_op[0] !== 16'hA1B2 || hq_pc[0] !== 12'hFFE) begin
      errors++;
      $display("FAIL wrap_opcode: got %p/%p required A1B2/FFE", hq_op, hq_pc);
    end
    checks++;
    if (rq.size() < 4 || rq[0] !== 12'hFFE || rq[1] !== 12'hFFF || rq[2] !== 12'h000 || rq[3] !== 12'h001) begin
      errors++;
      $display("FAIL wrap_addrs: got %p required FFE FFF 000 001", rq);
    end
  endtask

  task automatic test_redirect_wait();
    int n, lc;
    mem[12'h200] = 8'hEE; mem[12'h300] = 8'h55; mem[12'h301] = 8'h66;
    lat = 3;
    do_reset();
    n = 0;
    while (rq.size() == 0 && n < 20) begin tick(1'b0, 1'b0, '0); n++; end
    tick(1'b0, 1'b1, 12'h300);
    lc = cyc;
    n = rq.size();
    run_until_hs(1, "redirect_wait");
    checks++;
    if (rq.size() <= n || rq[n] !== 12'h300 || rc[n] != lc + 3) begin
      errors++;
      $display("FAIL rdw_next_fetch: addr=%h at +%0d required 300 at +3",
               rq.size() > n ? rq[n] : 12'hxxx, rc.size() > n ? rc[n] - lc : -1);
    end
    checks++;
    if (hq_op.size() < 1 || hq_op[0] !== 16'h5566 || hq_pc[0] !== 12'h300) begin
      errors++;
      $display("FAIL rdw_opcode: got %p/%p required 5566/300", hq_op, hq_pc);
    end
    lat = 1;
  endtask

  task automatic test_redirect_valid();
    int n, k;
    lat = 1;
    do_reset();
    n = 0;
    while (!bus.op_valid && n < 50) begin tick(1'b0, 1'b0, '0); n++; end
    k = rq.size();
    tick(1'b1, 1'b1, 12'h450);
    checks++;
    if (hq_pc.size() != 0) begin
      errors++;
      $display("FAIL rdv_no_handshake: handshakes=%0d required 0", hq_pc.size());
    end
    run_until_hs(1, "redirect_valid");
    checks++;
    if (hq_pc.size() < 1 || hq_pc[0] !== 12'h450 || hq_op[0] !== exp_op(12'h450)
        || rq.size() <= k || rq[k] !== 12'h450) begin
      errors++;
      $display("FAIL rdv_target: got %p/%p fetch=%p required 450/%h", hq_pc, hq_op, rq, exp_op(12'h450));
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_pc, la;
    logic rdy, ld;
    int hs;
    lat = 0;
    do_reset();
    exp_pc = 12'h200; hs = 0;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 1) == 1);
      ld  = ($urandom_range(0, 24) == 0);
      la  = 12'($urandom);
      tick(rdy, ld, la);
      if (hq_pc.size() > 0) begin
        logic [11:0] p;
        logic [15:0] o;
        p = hq_pc.pop_front(); o = hq_op.pop_front();
        hs++;
        checks++;
        if (p !== exp_pc || o !== exp_op(exp_pc)) begin
          errors++;
          $display("FAIL random_hs[%0d]: got %h/%h required %h/%h", hs, p, o, exp_pc, exp_op(exp_pc));
        end
        exp_pc = exp_pc + 12'd2;
      end
      if (ld) exp_pc = la;
    end
    checks++;
    if (hs < 20) begin
      errors++;
      $display("FAIL random_activity: handshakes %0d required at least 20", hs);
    end
    lat = 1;
  endtask

  task automatic test_fault();
    do_reset();
    tick(1'b1, 1'b1, 12'h201);
    repeat (8) tick(1'b1, 1'b0, '0);
`ifdef CHIP8_FETCH_ODD_PC_FAULT_EN
    checks++;
    if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b required 1", bus.fault); end
    repeat (20) tick(1'b1, 1'b0, '0);
    checks++;
    if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b required 1", bus.fault); end
`else
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_off: got %b required 0", bus.fault); end
    repeat (20) tick(1'b1, 1'b0, '0);
`endif
    checks++;
    if (hq_pc.size() < 2 || hq_pc[0] !== 12'h201 || hq_op[0] !== exp_op(12'h201) || hq_pc[1] !== 12'h203) begin
      errors++;
      $display("FAIL odd_fetch: got %p required 201 203", hq_pc);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    lat = 3;
    clear_logs();
    n = 0;
    while (rq.size() < 2 && n < 40) begin tick(1'b0, 1'b0, '0); n++; end
    tick(1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.op_valid !== 1'b0 || bus.fault !== 1'b0 || bus.reen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: op_valid=%b fault=%b reen=%b required 0 0 0", bus.op_valid, bus.fault, bus.reen);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    ov_prev = 1'b0;
    clear_logs();
    lat = 1;
    k = 0;
    while (rq.size() == 0 && k < 20) begin tick(1'b0, 1'b0, '0); k++; end
    checks++;
    if (rq.size() == 0 || rq[0] !== 12'h200) begin
      errors++;
      $display("FAIL reset_mid_pc: first fetch %h required 200", rq.size() > 0 ? rq[0] : 12'hxxx);
    end
  endtask

  initial begin
    bus.op_ready = 1'b0; bus.pc_load = 1'b0; bus.pc_load_addr = '0;
    ov_prev = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_redirect_wait();
    test_redirect_valid();
    test_random();
    test_fault();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
